// File: rtl/bram_sdp_be_if.sv
// bram_sdp_be_if : write port, read port and read response of the
// simple-dual-port byte-enable RAM, bundled as one interface.
// Signals:
//   wen    - write enable
//   wbe    - byte enables, bit i covers wdata[8i+7:8i]
//   waddr  - write address
//   wdata  - write data
//   ren    - read enable
//   raddr  - read address
//   rdata  - read data (holds its last value between responses)
//   rvalid - one-cycle strobe marking a read response on rdata
// Modports:
//   master - requester side (drives writes and reads, receives response)
//   slave  - RAM side
interface bram_sdp_be_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic                  wen;
  logic [DATA_W/8-1:0]   wbe;
  logic [ADDR_W-1:0]     waddr;
  logic [DATA_W-1:0]     wdata;
  logic                  ren;
  logic [ADDR_W-1:0]     raddr;
  logic [DATA_W-1:0]     rdata;
  logic                  rvalid;

  modport master (
    output wen, wbe, waddr, wdata, ren, raddr,
    input  rdata, rvalid
  );

  modport slave (
    input  wen, wbe, waddr, wdata, ren, raddr,
    output rdata, rvalid
  );

endinterface

// File: rtl/bram_sdp_be.sv
// bram_sdp_be : simple-dual-port block RAM (one write port, one read port,
// single clock) with per-byte write enables, a 1- or 2-stage registered
// read path with a read-valid strobe, and a selectable read-during-write
// collision mode (read-first or write-first).
// Ports:
//   clk  - clock, all logic on the rising edge
//   rstn - synchronous active-low reset; clears the read pipeline only,
//          the storage array is never cleared and writes are not blocked
//   bus  - bram_sdp_be_if.slave: wen/wbe/waddr/wdata write port,
//          ren/raddr read port, rdata/rvalid read response
module bram_sdp_be #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int RD_LATENCY  = 1,
  parameter int WRITE_FIRST = 0
) (
  input  logic         clk,
  input  logic         rstn,
  bram_sdp_be_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  // Reject configurations the read pipeline and byte lanes cannot express.
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("bram_sdp_be: RD_LATENCY must be 1 or 2");
  end
  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("bram_sdp_be: DATA_W must be a multiple of 8");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] issue_data;
  logic              collide;
  logic [DATA_W-1:0] s1_data;
  logic              s1_valid;

  // Byte-lane write; lanes with wbe clear keep their old contents.
  always_ff @(posedge clk) begin
    if (bus.wen) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wbe[i]) begin
          mem[bus.waddr][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

  assign collide = bus.ren && bus.wen && (bus.raddr == bus.waddr);

  // Word seen by a read at the issue edge. The array output is the
  // pre-write contents; in write-first mode an explicit bypass overlays the
  // enabled bytes of the colliding write so the reader sees the merged word.
  always_comb begin
    issue_data = mem[bus.raddr];
    if (WRITE_FIRST != 0 && collide) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wbe[i]) begin
          issue_data[8*i +: 8] = bus.wdata[8*i +: 8];
        end
      end
    end
  end

  // First read stage: captures the issue-cycle word. Data only loads on an
  // accepted read so it holds between responses; a read issued while rstn
  // is low is dropped.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= bus.ren;
      if (bus.ren) begin
        s1_data <= issue_data;
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_W-1:0] out_data;
    logic              out_valid;

    // Output stage: loads only when stage 1 carries a response, so rdata
    // keeps the last delivered word otherwise.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        out_valid <= 1'b0;
        out_data  <= '0;
      end else begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= s1_data;
        end
      end
    end

    assign bus.rdata  = out_data;
    assign bus.rvalid = out_valid;
  end else begin : g_lat1
    assign bus.rdata  = s1_data;
    assign bus.rvalid = s1_valid;
  end

endmodule

// File: tb/tb_bram_sdp_be.sv
// tb_bram_sdp_be : self-checking bench for bram_sdp_be. Four instances cover
// every RD_LATENCY / WRITE_FIRST combination and see identical stimulus.
// Index g: RD_LATENCY = 1 + g/2, WRITE_FIRST = g%2.
module tb_bram_sdp_be;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int NDUT = 4;
  localparam int NVEC = 25;

  typedef struct {
    logic          wen;
    logic [3:0]    wbe;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          ren;
    logic [AW-1:0] raddr;
    logic [DW-1:0] exp_rf;
    logic [DW-1:0] exp_wf;
  } vec_t;

  logic          clk;
  logic          rstn;
  logic          wen;
  logic [3:0]    wbe;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          ren;
  logic [AW-1:0] raddr;

  logic [DW-1:0] rdata_a  [NDUT];
  logic          rvalid_a [NDUT];

  int   total;
  int   bad;
  vec_t vecs [NVEC];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    bram_sdp_be_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    assign bus.wen   = wen;
    assign bus.wbe   = wbe;
    assign bus.waddr = waddr;
    assign bus.wdata = wdata;
    assign bus.ren   = ren;
    assign bus.raddr = raddr;
    assign rdata_a[g]  = bus.rdata;
    assign rvalid_a[g] = bus.rvalid;

    bram_sdp_be #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .RD_LATENCY(1 + g / 2),
      .WRITE_FIRST(g % 2)
    ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
    );
  end

  function automatic int lat_of(input int g);
    return 1 + g / 2;
  endfunction

  function automatic bit wf_of(input int g);
    return (g % 2) == 1;
  endfunction

  task automatic applyStimulus(input vec_t v);
    wen   = v.wen;
    wbe   = v.wbe;
    waddr = v.waddr;
    wdata = v.wdata;
    ren   = v.ren;
    raddr = v.raddr;
  endtask

  task automatic setIdle();
    wen   = 1'b0;
    wbe   = 4'h0;
    waddr = '0;
    wdata = '0;
    ren   = 1'b0;
    raddr = '0;
  endtask

  // Advance past one rising edge and settle a little after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int g, input logic exp_v,
                             input logic [DW-1:0] exp_d, input string tag);
    total++;
    if (rvalid_a[g] !== exp_v || rdata_a[g] !== exp_d) begin
      bad++;
      $display("[TB] FAIL %s dut%0d(lat=%0d wf=%0d): got rvalid=%b rdata=%h, want rvalid=%b rdata=%h",
               tag, g, lat_of(g), wf_of(g), rvalid_a[g], rdata_a[g], exp_v, exp_d);
    end
  endtask

  initial begin
    logic          pv   [NDUT];
    logic [DW-1:0] pd   [NDUT];
    logic [DW-1:0] hold [NDUT];
    int            rv_cnt [NDUT];
    logic          ev;
    logic [DW-1:0] ed;
    logic          nv;
    logic [DW-1:0] nd;
    logic [DW-1:0] ref_3ff;
    logic [DW-1:0] rnd;
    logic [3:0]    rbe;
    int            lat;

    total = 0;
    bad   = 0;

    // {wen, wbe, waddr, wdata, ren, raddr, expected read-first, expected write-first}
    vecs[0]  = '{1'b1, 4'hF, 10'd5, 32'hDEADBEEF, 1'b0, 10'd0, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 4'h0, 10'd0, 32'h0,        1'b1, 10'd5, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 4'h0, 10'd0, 32'h0,        1'b0, 10'd0, 32'h0, 32'h0};
    vecs[3]  = '{1'b1, 4'hF, 10'd3, 32'h11223344, 1'b0, 10'd0, 32'h0, 32'h0};
    vecs[4]  = '{1'b1, 4'h5, 10'd3, 32'hAABBCCDD, 1'b0, 10'd0, 32'h0, 32'h0};
    vecs[5]  = '{1'b0, 4'h0, 10'd0, 32'h0,        1'b1, 10'd3, 32'h11BB33DD, 32'h11BB33DD};
    vecs[6]  = '{1'b1, 4'hF, 10'd7, 32'h00000000, 1'b0, 10'd0, 32'h0, 32'h0};
    vecs[7]  = '{1'b1, 4'hC, 10'd7, 32'hFFFF0000, 1'b1, 10'd7, 32'h00000000, 32'hFFFF0000};
    vecs[8]  = '{1'b1, 4'h0, 10'd7, 32'h12345678, 1'b1, 10'd7, 32'hFFFF0000, 32'hFFFF0000};
    vecs[9]  = '{1'b1, 4'hF, 10'd5, 32'h55555555, 1'b1, 10'd7, 32'hFFFF0000, 32'hFFFF0000};
    vecs[10] = '{1'b0, 4'h0, 10'd0, 32'h0,        1'b1, 10'd5, 32'h55555555, 32'h55555555};
    vecs[11] = '{1'b1, 4'hF, 10'd5, 32'h66666666, 1'b1, 10'd3, 32'h11BB33DD, 32'h11BB33DD};
    vecs[12] = '{1'b0, 4'h0, 10'd0, 32'h0,        1'b1, 10'd5, 32'h66666666, 32'h66666666};
    vecs[13] = '{1'b0, 4'h0, 10'd0, 32'h0,        1'b0, 10'd0, 32'h0, 32'h0};
    vecs[14] = '{1'b0, 4'h0, 10'd0, 32'h0,        1'b0, 10'd0, 32'h0, 32'h0};
    vecs[15] = '{1'b1, 4'hF, 10'd0, 32'h10,       1'b0, 10'd0, 32'h0, 32'h0};
    vecs[16] = '{1'b1, 4'hF, 10'd1, 32'h11,       1'b0, 10'd0, 32'h0, 32'h0};
    vecs[17] = '{1'b1, 4'hF, 10'd2, 32'h12,       1'b0, 10'd0, 32'h0, 32'h0};
    vecs[18] = '{1'b1, 4'hF, 10'd3, 32'h13,       1'b0, 10'd0, 32'h0, 32'h0};
    vecs[19] = '{1'b0, 4'h0, 10'd0, 32'h0,        1'b1, 10'd0, 32'h10, 32'h10};
    vecs[20] = '{1'b0, 4'h0, 10'd0, 32'h0,        1'b1, 10'd1, 32'h11, 32'h11};
    vecs[21] = '{1'b0, 4'h0, 10'd0, 32'h0,        1'b1, 10'd2, 32'h12, 32'h12};
    vecs[22] = '{1'b0, 4'h0, 10'd0, 32'h0,        1'b1, 10'd3, 32'h13, 32'h13};
    vecs[23] = '{1'b0, 4'h0, 10'd0, 32'h0,        1'b0, 10'd0, 32'h0, 32'h0};
    vecs[24] = '{1'b0, 4'h0, 10'd0, 32'h0,        1'b0, 10'd0, 32'h0, 32'h0};

    // Reset state
    rstn = 1'b0;
    setIdle();
    tick();
    tick();
    for (int g = 0; g < NDUT; g++) checkOutput(g, 1'b0, 32'h0, "reset_state");
    rstn = 1'b1;

    // Table-driven section; responses are expected RD_LATENCY edges after issue
    for (int g = 0; g < NDUT; g++) begin
      pv[g]   = 1'b0;
      pd[g]   = '0;
      hold[g] = '0;
    end
    for (int k = 0; k < NVEC; k++) begin
      applyStimulus(vecs[k]);
      tick();
      for (int g = 0; g < NDUT; g++) begin
        nv = vecs[k].ren;
        nd = wf_of(g) ? vecs[k].exp_wf : vecs[k].exp_rf;
        if (lat_of(g) == 1) begin
          ev = nv;
          ed = nd;
        end else begin
          ev    = pv[g];
          ed    = pd[g];
          pv[g] = nv;
          pd[g] = nd;
        end
        if (ev) hold[g] = ed;
        checkOutput(g, ev, hold[g], $sformatf("vec%0d", k));
      end
    end

    // Reset while a read is in flight; a read issued during reset is dropped
    setIdle();
    ren   = 1'b1;
    raddr = 10'd1;
    tick();
    for (int g = 0; g < NDUT; g++) begin
      if (lat_of(g) == 1) checkOutput(g, 1'b1, 32'h11, "pre_reset_read");
      else                checkOutput(g, 1'b0, 32'h13, "pre_reset_read");
    end
    rstn  = 1'b0;
    raddr = 10'd2;
    tick();
    for (int g = 0; g < NDUT; g++) checkOutput(g, 1'b0, 32'h0, "mid_reset");
    rstn = 1'b1;
    setIdle();
    for (int t = 0; t < 3; t++) begin
      tick();
      for (int g = 0; g < NDUT; g++) checkOutput(g, 1'b0, 32'h0, "no_stray_rvalid");
    end
    ren   = 1'b1;
    raddr = 10'd1;
    for (int t = 0; t < 3; t++) begin
      tick();
      setIdle();
      for (int g = 0; g < NDUT; g++) begin
        lat = lat_of(g);
        if (t == lat - 1)   checkOutput(g, 1'b1, 32'h11, "post_reset_read");
        else if (t < lat - 1) checkOutput(g, 1'b0, 32'h0, "post_reset_read");
        else                checkOutput(g, 1'b0, 32'h11, "post_reset_read");
      end
    end

    // Independent ports: random writes to 0x3FF while reading addr 0 each cycle
    ref_3ff = '0;
    for (int g = 0; g < NDUT; g++) rv_cnt[g] = 0;
    for (int t = 0; t < 18; t++) begin
      if (t < 16) begin
        rnd   = $urandom;
        rbe   = (t == 0) ? 4'hF : 4'($urandom_range(0, 15));
        wen   = 1'b1;
        wbe   = rbe;
        waddr = 10'h3FF;
        wdata = rnd;
        ren   = 1'b1;
        raddr = 10'd0;
        for (int b = 0; b < 4; b++) begin
          if (rbe[b]) ref_3ff[8*b +: 8] = rnd[8*b +: 8];
        end
      end else begin
        setIdle();
      end
      tick();
      for (int g = 0; g < NDUT; g++) begin
        lat = lat_of(g);
        if (rvalid_a[g] === 1'b1) rv_cnt[g]++;
        if (t >= lat - 1 && t < 16 + lat - 1) checkOutput(g, 1'b1, 32'h10, "indep_read");
        else if (t < lat - 1)                 checkOutput(g, 1'b0, 32'h11, "indep_read");
        else                                  checkOutput(g, 1'b0, 32'h10, "indep_read");
      end
    end
    setIdle();
    for (int g = 0; g < NDUT; g++) begin
      total++;
      if (rv_cnt[g] != 16) begin
        bad++;
        $display("[TB] FAIL indep_rvalid_count dut%0d: got %0d, want 16", g, rv_cnt[g]);
      end
    end

    // Read back the word the random writes built up
    ren   = 1'b1;
    raddr = 10'h3FF;
    for (int t = 0; t < 2; t++) begin
      tick();
      setIdle();
      for (int g = 0; g < NDUT; g++) begin
        lat = lat_of(g);
        if (t == lat - 1)     checkOutput(g, 1'b1, ref_3ff, "indep_readback");
        else if (t < lat - 1) checkOutput(g, 1'b0, 32'h10, "indep_readback");
        else                  checkOutput(g, 1'b0, ref_3ff, "indep_readback");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_sdp_be.md
Name: bram_sdp_be

Overview:
- Parametrised simple-dual-port block RAM: one write port, one read port, same clock.
- Adds three features to the basic single-word RAM:
  - per-byte write enables;
  - configurable read latency (1 or 2 register stages) with a read-valid strobe;
  - selectable read-during-write collision mode.
- General on-chip storage for buffers, register files and FIFO back-ends; maps to vendor BRAM.

Parameters:
- ADDR_W, 10, address width; depth = 2**ADDR_W words.
- DATA_W, 32, word width in bits; must be a multiple of 8.
- RD_LATENCY, 1, cycles from read issue to rdata/rvalid; legal values 1 or 2, others fail elaboration.
- WRITE_FIRST, 0, collision mode: 0 = read-first (old data), 1 = write-first (new data).

Ports:
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  synchronous reset, active-low
- wen  in  1  write enable
- wbe  in  DATA_W/8  byte enables; bit i covers wdata[8i+7:8i]
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- ren  in  1  read enable
- raddr  in  ADDR_W  read address
- rdata  out  DATA_W  read data
- rvalid  out  1  rdata holds the response to a read issued RD_LATENCY cycles earlier

Behaviour:
- Storage array is not reset; contents are X until written. rstn does not block writes.
- Write:
  - On a clk edge with wen=1, byte i of mem[waddr] takes wdata byte i for every wbe[i]=1.
  - Other bytes are unchanged.
  - wen=1 with wbe=0 is a no-op.
- Read issue: ren=1 at edge N samples raddr.
- RD_LATENCY=1: rdata and rvalid update at edge N; both visible in cycle N+1.
- RD_LATENCY=2:
  - stage-1 register captures the array output at edge N;
  - output register captures stage 1 at edge N+1;
  - rvalid is pipelined alongside.
  - Back-to-back reads are accepted every cycle; throughput is 1 read/cycle in both latencies.
- rvalid:
  - 1 for exactly one cycle per accepted read;
  - 0 otherwise.
- rdata hold:
  - When no response is delivered, rdata holds its last value; it is never cleared to 0 except by reset.
  - For RD_LATENCY=2, the output register loads only when stage 1 is valid.
- Collision (ren=1, wen=1, raddr==waddr at the same edge):
  - WRITE_FIRST=0: returned word is the pre-write contents.
  - WRITE_FIRST=1: returned word is a byte-merge. Bytes with wbe[i]=1 take wdata; the others take the old contents.
  - Implement the merge as an explicit bypass mux on the issue-cycle data, not by relying on inference.
- No forwarding beyond the issue edge: a write to the same address at edge N+1 does not alter a read issued at edge N, in either latency.
- Different addresses at the same edge: fully independent.
- Reset:
  - rstn=0 at an edge clears rdata to 0, rvalid to 0 and all pipeline valid bits to 0.
  - A read in flight when reset asserts is discarded; no rvalid appears after reset deasserts for it.
  - A read issued in the same cycle as rstn=0 is dropped.
- Address wrap: waddr/raddr span the full 2**ADDR_W range; no out-of-range case exists.

Test Plan:
- RD_LATENCY=1:
  - write 0xDEADBEEF to addr 5 with wbe=4'hF;
  - next cycle, read addr 5;
  - rvalid=1 and rdata=0xDEADBEEF exactly one cycle after the read edge;
  - rvalid=0 in the following cycle while rdata holds 0xDEADBEEF.
- Byte enables:
  - addr 3 holds 0x11223344; write 0xAABBCCDD with wbe=4'b0101;
  - read addr 3 returns 0x11BB33DD.
- Collision, addr 7 holding 0x00000000, write 0xFFFF0000 wbe=4'b1100 and read in the same cycle:
  - WRITE_FIRST=0 returns 0x00000000;
  - WRITE_FIRST=1 returns 0xFFFF0000;
  - a subsequent read returns 0xFFFF0000 in both modes.
- RD_LATENCY=2 streaming:
  - preload addrs 0..3 with 0x10..0x13; issue ren on 4 consecutive cycles;
  - rvalid high for 4 consecutive cycles starting 2 cycles after the first issue;
  - rdata sequence 0x10, 0x11, 0x12, 0x13.
- Reset mid-operation (RD_LATENCY=2):
  - issue read of addr 1, then assert rstn=0 on the next edge;
  - rdata=0, rvalid=0 after reset, no stray rvalid afterwards;
  - after rstn=1, a read of addr 1 still returns the preloaded value, because the array is not cleared.
- Independent ports:
  - write addr 0x3FF while reading addr 0 every cycle for 16 cycles with random data;
  - scoreboard against a reference model with zero mismatches and rvalid count = 16.
